// File: rtl/w_coder.sv
// w_coder: per-line pixel delta coder feeding a first-word-fall-through byte FIFO.
// Each line is coded as its first pixel raw, then the 8-bit difference to the
// previous pixel for every later pixel, then one trailer byte holding the
// 8-bit sum of the raw pixels. A consumer pops bytes on rising edges of dclk.
module w_coder #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned DW    = 8
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          vsync,
    input  logic          href,
    input  logic [DW-1:0] din,
    output logic          ready,
    input  logic          dclk,
    output logic [DW-1:0] dout,
    output logic          ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] prev;
    logic [DW-1:0] sum;
    logic [DW-1:0] last;
    logic          first;
    logic          href_d;
    logic          dclk_d;

    logic          cap;
    logic          eol;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic [DW-1:0] push_data;

    // Capture, end-of-line, pop and overflow decisions for this edge
    always_comb begin
        cap       = href & ~vsync;
        eol       = href_d & ~href & ~vsync;
        push      = cap | eol;
        full      = (count == CW'(DEPTH));
        pop       = dclk & ~dclk_d & (count != '0) & ~vsync;
        // A full FIFO still accepts a push when the head leaves on the same edge
        push_ok   = push & (~full | pop);
        drop      = push & full & ~pop;
        push_data = din;
        if (eol) begin
            push_data = sum;
        end else if (!first) begin
            push_data = din - prev;
        end
    end

    // Line coding state, FIFO pointers/occupancy and sticky overflow
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prev   <= '0;
            sum    <= '0;
            last   <= '0;
            first  <= 1'b1;
            href_d <= 1'b0;
            dclk_d <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            href_d <= href;
            dclk_d <= dclk;
            if (vsync) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf    <= 1'b0;
                sum    <= '0;
                prev   <= '0;
                first  <= 1'b1;
                // Keep dout showing whatever was at the head when flushed
                if (count != '0) begin
                    last <= mem[rd_ptr];
                end
            end else begin
                if (cap) begin
                    prev  <= din;
                    sum   <= sum + din;
                    first <= 1'b0;
                end else if (eol) begin
                    sum   <= '0;
                    first <= 1'b1;
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    last   <= mem[rd_ptr];
                end
                if (drop) begin
                    ovf <= 1'b1;
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage write port
    always_ff @(posedge pclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign ready = (count != '0);
    assign dout  = ready ? mem[rd_ptr] : last;

endmodule

// File: tb/tb_w_coder.sv
// Self-checking bench for w_coder: line coding, FIFO drain, overflow,
// strobe edge rule, push/pop overlap and asynchronous reset.
module tb_w_coder;

    logic       pclk;
    logic       rst_n;
    logic       vsync;
    logic       href;
    logic [7:0] din;
    logic       ready;
    logic       dclk;
    logic [7:0] dout;
    logic       ovf;

    int checks;
    int failures;

    logic [7:0]  exp_q[$];
    logic [7:0]  got[$];
    int unsigned px[$];

    w_coder #(.DEPTH(32), .DW(8)) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .vsync (vsync),
        .href  (href),
        .din   (din),
        .ready (ready),
        .dclk  (dclk),
        .dout  (dout),
        .ovf   (ovf)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got running, required finished");
        $fatal(1, "timeout");
    end

    // Reference: expected coded bytes for one complete line of raw pixels
    function automatic void model_line(input int unsigned pix[$]);
        int unsigned s;
        s = 0;
        for (int i = 0; i < pix.size(); i++) begin
            if (i == 0) exp_q.push_back(8'(pix[i] % 256));
            else        exp_q.push_back(8'((pix[i] + 256 - pix[i-1]) % 256));
            s = s + pix[i];
        end
        exp_q.push_back(8'(s % 256));
    endfunction

    // All driving tasks start and end just after a falling edge
    task automatic do_reset();
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; dclk = 1'b0; din = 8'd0;
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        @(negedge pclk);
        vsync = 1'b0;
        @(negedge pclk);
    endtask

    // mode 0: no pops, 1: random pops, 2: pop whenever possible
    task automatic send_line(input int unsigned pix[$], input int mode);
        int n;
        n = pix.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                href = 1'b1;
                din  = 8'(pix[i]);
            end else begin
                href = 1'b0;
            end
            if (mode != 0) begin
                if (dclk) begin
                    dclk = 1'b0;
                end else if (ready && (mode == 2 || $urandom_range(0, 1) == 1)) begin
                    got.push_back(dout);
                    dclk = 1'b1;
                end
            end
            @(negedge pclk);
        end
        dclk = 1'b0;
        @(negedge pclk);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && ready; k++) begin
            got.push_back(dout);
            dclk = 1'b1;
            @(negedge pclk);
            dclk = 1'b0;
            @(negedge pclk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++;
        if (dout !== 8'd0) begin failures++; $display("FAIL reset_dout got %0d exp 0", dout); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_single_line();
        vsync_pulse();
        px.delete(); exp_q.delete(); got.delete();
        for (int p = 1; p <= 21; p++) px.push_back(p);
        model_line(px);
        send_line(px, 0);
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL line_ready got %b exp 1", ready); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL line_ovf got %b exp 0", ovf); end
        drain();
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL line_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL line_byte[%0d] got %0d exp %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_three_lines();
        vsync_pulse();
        exp_q.delete(); got.delete();
        for (int l = 0; l < 3; l++) begin
            px.delete();
            for (int p = 0; p < 21; p++) px.push_back(p + l + 1);
            model_line(px);
            send_line(px, 2);
            drain();
        end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL three_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL three_byte[%0d] got %0d exp %0d", i, got[i], exp_q[i]); end
        end
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL three_ready got %b exp 0", ready); end
    endtask

    task automatic test_wrap();
        vsync_pulse();
        exp_q.delete(); got.delete();
        px = '{250, 4, 4};
        model_line(px);
        send_line(px, 0);
        drain();
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL wrap_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_byte[%0d] got %0d exp %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        vsync_pulse();
        exp_q.delete(); got.delete(); px.delete();
        for (int p = 0; p < 40; p++) px.push_back(7);
        model_line(px);
        while (exp_q.size() > 32) void'(exp_q.pop_back());
        send_line(px, 0);
        checks++;
        if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got %b exp 1", ovf); end
        drain();
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL ovf_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte[%0d] got %0d exp %0d", i, got[i], exp_q[i]); end
        end
        checks++;
        if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
        px = '{3, 9, 1};
        send_line(px, 0);
        vsync_pulse();
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL ovf_flush_ready got %b exp 0", ready); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    endtask

    task automatic test_overlap();
        vsync_pulse();
        got.delete();
        px = '{5, 7};
        send_line(px, 0);
        // Queue holds 5, 2, 12; a held strobe must pop exactly once
        dclk = 1'b1;
        repeat (3) @(negedge pclk);
        dclk = 1'b0;
        @(negedge pclk);
        checks++;
        if (dout !== 8'd2) begin failures++; $display("FAIL hold_pop_head got %0d exp 2", dout); end
        // Strobe rise together with a pixel push: head 2 leaves, raw 9 enters
        href = 1'b1; din = 8'd9; dclk = 1'b1;
        @(negedge pclk);
        href = 1'b0; dclk = 1'b0;
        checks++;
        if (dout !== 8'd12) begin failures++; $display("FAIL overlap_head got %0d exp 12", dout); end
        @(negedge pclk);
        @(negedge pclk);
        drain();
        exp_q = '{8'd12, 8'd9, 8'd9};
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL overlap_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL overlap_byte[%0d] got %0d exp %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        vsync_pulse();
        for (int i = 0; i < 5; i++) begin
            href = 1'b1;
            din  = 8'($urandom_range(1, 255));
            @(negedge pclk);
        end
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL midline_ready got %b exp 1", ready); end
        rst_n = 1'b0;
        href  = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL async_ready got %b exp 0", ready); end
        checks++;
        if (dout !== 8'd0) begin failures++; $display("FAIL async_dout got %0d exp 0", dout); end
        @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        exp_q.delete(); got.delete(); px.delete();
        for (int i = 0; i < 4; i++) px.push_back($urandom_range(0, 255));
        model_line(px);
        send_line(px, 0);
        drain();
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL restart_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL restart_byte[%0d] got %0d exp %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        vsync_pulse();
        exp_q.delete(); got.delete();
        for (int l = 0; l < 3; l++) begin
            px.delete();
            for (int p = 0; p < int'($urandom_range(1, 9)); p++) px.push_back($urandom_range(0, 255));
            model_line(px);
            send_line(px, 1);
        end
        drain();
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL rand_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte[%0d] got %0d exp %0d", i, got[i], exp_q[i]); end
        end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL rand_ovf got %b exp 0", ovf); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_line();
        test_three_lines();
        test_wrap();
        test_overflow();
        test_overlap();
        test_mid_reset();
        for (int r = 0; r < 4; r++) test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
